// File: rtl/alu_seq_unit_if.sv
// Handshake bundle between operand fetch, alu_seq_unit and writeback.
// The producer/consumer side uses master; the unit itself uses slave.
interface alu_seq_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic [3:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_ovf;

    modport master (
        output in_valid, src1, src2, op, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf
    );

    modport slave (
        input  in_valid, src1, src2, op, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf
    );
endinterface

// File: rtl/alu_seq_unit.sv
// Handshaked ALU with registered result/flags and an iterative shift-add
// multiplier that takes WIDTH enabled clocks per MUL.
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    alu_seq_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state;
    logic [SHW-1:0]     count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] next_acc;

    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               carry_q;
    logic               ovf_q;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic [SHW-1:0]     shamt;
    logic               ready;
    logic               accept;

    assign ready  = enable && !reset && (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept = bus.in_valid && ready;
    assign shamt  = bus.src2[SHW-1:0];

    assign bus.in_ready   = ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_carry = carry_q;
    assign bus.flag_ovf   = ovf_q;

    // Single-cycle datapath; SUB's extra MSB is the unsigned borrow.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                {alu_carry, alu_res} = {1'b0, bus.src1} + {1'b0, bus.src2};
                alu_ovf = (bus.src1[WIDTH-1] == bus.src2[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.src1[WIDTH-1]);
            end
            OP_SUB: begin
                {alu_carry, alu_res} = {1'b0, bus.src1} - {1'b0, bus.src2};
                alu_ovf = (bus.src1[WIDTH-1] != bus.src2[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.src1[WIDTH-1]);
            end
            OP_AND:  alu_res = bus.src1 & bus.src2;
            OP_OR:   alu_res = bus.src1 | bus.src2;
            OP_XOR:  alu_res = bus.src1 ^ bus.src2;
            OP_SLL:  alu_res = bus.src1 << shamt;
            OP_SRL:  alu_res = bus.src1 >> shamt;
            default: alu_res = '0;
        endcase
    end

    assign next_acc = acc + (mplier[0] ? mcand : '0);

    // An accepted MUL always frees the output, so out_valid is 0 throughout MUL.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.op == OP_MUL) begin
                            mcand       <= {{WIDTH{1'b0}}, bus.src1};
                            mplier      <= bus.src2;
                            acc         <= '0;
                            count       <= '0;
                            out_valid_q <= 1'b0;
                            state       <= MUL;
                        end else begin
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                            carry_q     <= alu_carry;
                            ovf_q       <= alu_ovf;
                            out_valid_q <= 1'b1;
                        end
                    end else if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                MUL: begin
                    if (count == SHW'(WIDTH - 1)) begin
                        result_q    <= next_acc[WIDTH-1:0];
                        zero_q      <= (next_acc[WIDTH-1:0] == '0);
                        carry_q     <= |next_acc[2*WIDTH-1:WIDTH];
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        acc    <= next_acc;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + SHW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
